nunchuk_packet_decoder: RTL and testbench

// Receiving end of the controller link. Consumes the 6-byte Nunchuk report stream from the
// I2C byte reader and decodes it into stick, accel and button fields.

---
 rtl/nunchuk_packet_decoder_if.sv | 10 +
 rtl/nunchuk_packet_decoder.sv | 171 +++++++++++++++++
 tb/tb_nunchuk_packet_decoder.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nunchuk_packet_decoder_if.sv
// Byte stream from the I2C byte reader into the Nunchuk packet decoder.
// The reader drives the stream, and the decoder accepts it unconditionally.
interface nunchuk_packet_decoder_if;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_first;

    modport master (output byte_valid, output byte_data, output byte_first);
    modport slave  (input  byte_valid, input  byte_data, input  byte_first);
endinterface

// File: rtl/nunchuk_packet_decoder.sv
// Assembles 6-byte Nunchuk reports into a held, registered sample.
// Produces stick/accel/button fields, a start pulse, link status and an error count.
module nunchuk_packet_decoder #(
    parameter bit          DECODE_XOR     = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned STICK_DEADZONE = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    nunchuk_packet_decoder_if.slave  rx,
    output logic [7:0]               stick_x,
    output logic [7:0]               stick_y,
    output logic [9:0]               accel_x,
    output logic [9:0]               accel_y,
    output logic [9:0]               accel_z,
    output logic                     z_btn,
    output logic                     c_btn,
    output logic                     sample_valid,
    output logic                     start_pulse,
    output logic                     link_up,
    output logic [7:0]               err_count
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] COLLECT = 1'b1;

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [0:0]    state;
    logic [2:0]    idx;
    logic [7:0]    pkt [0:5];
    logic [TW-1:0] idle_cnt;

    logic [7:0] cur;
    logic       is_last;
    logic       all_ff;
    logic       timeout;
    logic       err_inc;
    logic       z_new;
    logic       c_new;

    function automatic logic [7:0] decode(input logic [7:0] b);
        logic [7:0] d;
        d = b;
        if (DECODE_XOR)
            d = (b ^ 8'h17) + 8'h17;
        return d;
    endfunction

    function automatic logic [7:0] deadzone(input logic [7:0] s);
        logic signed [8:0] diff;
        logic        [8:0] mag;
        logic        [7:0] r;
        diff = $signed({1'b0, s}) - 9'sd128;
        mag  = (diff < 0) ? 9'(-diff) : 9'(diff);
        r    = s;
        if (STICK_DEADZONE != 0 && 32'(mag) < STICK_DEADZONE)
            r = 8'd128;
        return r;
    endfunction

    // The sixth byte is decoded straight from the bus, so the commit is registered
    // on the same edge and a byte in the following cycle never disturbs it.
    always_comb begin
        cur     = decode(rx.byte_data);
        is_last = 1'b0;
        all_ff  = 1'b0;
        timeout = 1'b0;
        err_inc = 1'b0;
        z_new   = ~cur[0];
        c_new   = ~cur[1];
        if (state == COLLECT && rx.byte_valid && !rx.byte_first && idx == 3'd5)
            is_last = 1'b1;
        if (pkt[0] == 8'hFF && pkt[1] == 8'hFF && pkt[2] == 8'hFF &&
            pkt[3] == 8'hFF && pkt[4] == 8'hFF && cur == 8'hFF)
            all_ff = 1'b1;
        if (state == COLLECT && !rx.byte_valid && idle_cnt == TIMEOUT_LAST)
            timeout = 1'b1;
        if (state == IDLE && rx.byte_valid && !rx.byte_first)
            err_inc = 1'b1;
        if (state == COLLECT && rx.byte_valid && rx.byte_first)
            err_inc = 1'b1;
        if (timeout || (is_last && all_ff))
            err_inc = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            idle_cnt <= '0;
            for (int unsigned i = 0; i < 6; i++)
                pkt[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx.byte_valid && rx.byte_first) begin
                        pkt[0]   <= cur;
                        idx      <= 3'd1;
                        idle_cnt <= '0;
                        state    <= COLLECT;
                    end
                end
                default: begin
                    if (rx.byte_valid) begin
                        idle_cnt <= '0;
                        if (rx.byte_first) begin
                            pkt[0] <= cur;
                            idx    <= 3'd1;
                        end else begin
                            pkt[idx] <= cur;
                            if (idx == 3'd5) begin
                                idx   <= '0;
                                state <= IDLE;
                            end else begin
                                idx <= idx + 3'd1;
                            end
                        end
                    end else if (timeout) begin
                        idx      <= '0;
                        idle_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stick_x      <= 8'd128;
            stick_y      <= 8'd128;
            accel_x      <= 10'd512;
            accel_y      <= 10'd512;
            accel_z      <= 10'd512;
            z_btn        <= 1'b0;
            c_btn        <= 1'b0;
            sample_valid <= 1'b0;
            start_pulse  <= 1'b0;
            link_up      <= 1'b0;
            err_count    <= '0;
        end else begin
            sample_valid <= 1'b0;
            start_pulse  <= 1'b0;
            if (is_last) begin
                if (all_ff) begin
                    link_up <= 1'b0;
                end else begin
                    stick_x      <= deadzone(pkt[0]);
                    stick_y      <= deadzone(pkt[1]);
                    accel_x      <= {pkt[2], cur[3:2]};
                    accel_y      <= {pkt[3], cur[5:4]};
                    accel_z      <= {pkt[4], cur[7:6]};
                    z_btn        <= z_new;
                    c_btn        <= c_new;
                    sample_valid <= 1'b1;
                    start_pulse  <= (z_new & ~z_btn) | (c_new & ~c_btn);
                    link_up      <= 1'b1;
                end
            end
            if (timeout)
                link_up <= 1'b0;
            if (err_inc && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_nunchuk_packet_decoder.sv
// Scoreboard bench: one raw decoder (XOR off) and one de-obfuscating decoder on a shared clock.
module tb_nunchuk_packet_decoder;

    localparam int TO = 40;
    localparam int DZ = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    nunchuk_packet_decoder_if if0 ();
    nunchuk_packet_decoder_if if1 ();

    logic [7:0] sx [2];
    logic [7:0] sy [2];
    logic [9:0] ax [2];
    logic [9:0] ay [2];
    logic [9:0] az [2];
    logic       zb [2];
    logic       cb [2];
    logic       sv [2];
    logic       sp [2];
    logic       lk [2];
    logic [7:0] ec [2];

    nunchuk_packet_decoder #(.DECODE_XOR(1'b0), .TIMEOUT_CYCLES(TO), .STICK_DEADZONE(DZ)) dut0 (
        .clk(clk), .rst_n(rst_n), .rx(if0),
        .stick_x(sx[0]), .stick_y(sy[0]), .accel_x(ax[0]), .accel_y(ay[0]), .accel_z(az[0]),
        .z_btn(zb[0]), .c_btn(cb[0]), .sample_valid(sv[0]), .start_pulse(sp[0]),
        .link_up(lk[0]), .err_count(ec[0]));

    nunchuk_packet_decoder #(.DECODE_XOR(1'b1), .TIMEOUT_CYCLES(TO), .STICK_DEADZONE(DZ)) dut1 (
        .clk(clk), .rst_n(rst_n), .rx(if1),
        .stick_x(sx[1]), .stick_y(sy[1]), .accel_x(ax[1]), .accel_y(ay[1]), .accel_z(az[1]),
        .z_btn(zb[1]), .c_btn(cb[1]), .sample_valid(sv[1]), .start_pulse(sp[1]),
        .link_up(lk[1]), .err_count(ec[1]));

    typedef struct {
        logic [7:0] sx;
        logic [7:0] sy;
        logic [9:0] ax;
        logic [9:0] ay;
        logic [9:0] az;
        logic       z;
        logic       c;
        logic       sp;
    } sample_t;

    sample_t q0 [$];
    sample_t q1 [$];
    sample_t last_s [2];
    int      checks = 0;
    int      passed = 0;
    int      exp_err [2];
    logic    exp_link [2];

    function automatic logic [7:0] mdl_dec(input int d, input logic [7:0] b);
        logic [7:0] r;
        r = b;
        if (d == 1) r = (b ^ 8'h17) + 8'h17;
        return r;
    endfunction

    function automatic logic [7:0] mdl_dz(input logic [7:0] s);
        int dv;
        dv = int'(s) - 128;
        if (dv < 0) dv = -dv;
        return (dv < DZ) ? 8'd128 : s;
    endfunction

    function automatic sample_t reset_sample();
        sample_t s;
        s.sx = 8'd128; s.sy = 8'd128;
        s.ax = 10'd512; s.ay = 10'd512; s.az = 10'd512;
        s.z = 1'b0; s.c = 1'b0; s.sp = 1'b0;
        return s;
    endfunction

    task automatic bump_err(input int d);
        if (exp_err[d] < 255) exp_err[d]++;
    endtask

    task automatic expect_pkt(input int d, input logic [47:0] raw);
        logic [7:0] b [6];
        logic       ff;
        sample_t    s;
        ff = 1'b1;
        for (int k = 0; k < 6; k++) begin
            b[k] = mdl_dec(d, raw[47-8*k -: 8]);
            if (b[k] != 8'hFF) ff = 1'b0;
        end
        if (ff) begin
            bump_err(d);
            exp_link[d] = 1'b0;
        end else begin
            s.sx = mdl_dz(b[0]);
            s.sy = mdl_dz(b[1]);
            s.ax = {b[2], b[5][3:2]};
            s.ay = {b[3], b[5][5:4]};
            s.az = {b[4], b[5][7:6]};
            s.z  = ~b[5][0];
            s.c  = ~b[5][1];
            s.sp = (s.z & ~last_s[d].z) | (s.c & ~last_s[d].c);
            last_s[d]   = s;
            exp_link[d] = 1'b1;
            if (d == 0) q0.push_back(s); else q1.push_back(s);
        end
    endtask

    task automatic drive(input int d, input logic [7:0] data, input logic first);
        if (d == 0) begin
            if0.byte_valid = 1'b1; if0.byte_data = data; if0.byte_first = first;
        end else begin
            if1.byte_valid = 1'b1; if1.byte_data = data; if1.byte_first = first;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int d);
        if (d == 0) begin
            if0.byte_valid = 1'b0; if0.byte_first = 1'b0;
        end else begin
            if1.byte_valid = 1'b0; if1.byte_first = 1'b0;
        end
    endtask

    task automatic send_pkt(input int d, input logic [47:0] raw);
        expect_pkt(d, raw);
        for (int k = 0; k < 6; k++) drive(d, raw[47-8*k -: 8], k == 0);
        idle(d);
    endtask

    task automatic drain(input int d, input string name);
        int n;
        repeat (3) @(negedge clk);
        n = (d == 0) ? q0.size() : q1.size();
        checks++;
        if (n != 0) $display("FAIL %s: %0d expected samples never appeared (want 0 pending)", name, n);
        else passed++;
    endtask

    task automatic check_status(input int d, input string name);
        checks++;
        if (ec[d] !== 8'(exp_err[d])) $display("FAIL %s err_count: got %0d want %0d", name, ec[d], exp_err[d]);
        else passed++;
        checks++;
        if (lk[d] !== exp_link[d]) $display("FAIL %s link_up: got %0b want %0b", name, lk[d], exp_link[d]);
        else passed++;
    endtask

    task automatic check_held(input int d, input string name);
        checks++;
        if (sx[d] !== last_s[d].sx || sy[d] !== last_s[d].sy || ax[d] !== last_s[d].ax ||
            ay[d] !== last_s[d].ay || az[d] !== last_s[d].az || zb[d] !== last_s[d].z || cb[d] !== last_s[d].c)
            $display("FAIL %s held outputs: got sx=%0d sy=%0d ax=%0d ay=%0d az=%0d z=%0b c=%0b want sx=%0d sy=%0d ax=%0d ay=%0d az=%0d z=%0b c=%0b",
                     name, sx[d], sy[d], ax[d], ay[d], az[d], zb[d], cb[d], last_s[d].sx, last_s[d].sy,
                     last_s[d].ax, last_s[d].ay, last_s[d].az, last_s[d].z, last_s[d].c);
        else passed++;
        checks++;
        if (sv[d] !== 1'b0 || sp[d] !== 1'b0) $display("FAIL %s pulses idle: got sv=%0b sp=%0b want 0 0", name, sv[d], sp[d]);
        else passed++;
    endtask

    always @(negedge clk) begin
        sample_t e;
        for (int d = 0; d < 2; d++) begin
            if (sv[d] === 1'b1) begin
                checks++;
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    $display("FAIL unexpected sample dut%0d: got sample_valid=1 want 0", d);
                end else begin
                    if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
                    if (sx[d] !== e.sx || sy[d] !== e.sy || ax[d] !== e.ax || ay[d] !== e.ay ||
                        az[d] !== e.az || zb[d] !== e.z || cb[d] !== e.c || sp[d] !== e.sp || lk[d] !== 1'b1)
                        $display("FAIL sample dut%0d: got sx=%0d sy=%0d ax=%0d ay=%0d az=%0d z=%0b c=%0b sp=%0b link=%0b want sx=%0d sy=%0d ax=%0d ay=%0d az=%0d z=%0b c=%0b sp=%0b link=1",
                                 d, sx[d], sy[d], ax[d], ay[d], az[d], zb[d], cb[d], sp[d], lk[d],
                                 e.sx, e.sy, e.ax, e.ay, e.az, e.z, e.c, e.sp);
                    else passed++;
                end
            end else if (sp[d] === 1'b1) begin
                checks++;
                $display("FAIL stray start_pulse dut%0d: got 1 want 0 without sample_valid", d);
            end
        end
    end

    task automatic clear_models();
        q0.delete(); q1.delete();
        for (int d = 0; d < 2; d++) begin
            last_s[d] = reset_sample(); exp_err[d] = 0; exp_link[d] = 1'b0;
        end
    endtask

    task automatic test_reset();
        idle(0); idle(1);
        if0.byte_data = '0; if1.byte_data = '0;
        clear_models();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_held(d, "reset");
            check_status(d, "reset");
        end
    endtask

    task automatic test_basic();
        send_pkt(0, 48'h80FF40C020E4);
        drain(0, "basic");
        checks++;
        if (sx[0] !== 8'd128 || sy[0] !== 8'd255 || ax[0] !== 10'd257 || ay[0] !== 10'd770 ||
            az[0] !== 10'd131 || zb[0] !== 1'b1 || cb[0] !== 1'b1)
            $display("FAIL basic fields: got %0d/%0d %0d %0d %0d z=%0b c=%0b want 128/255 257 770 131 z=1 c=1",
                     sx[0], sy[0], ax[0], ay[0], az[0], zb[0], cb[0]);
        else passed++;
        check_status(0, "basic");
    endtask

    task automatic test_repeat();
        send_pkt(0, 48'h80FF40C020E4);
        drain(0, "repeat same");
        send_pkt(0, 48'h80FF40C020E7);
        drain(0, "release");
        checks++;
        if (zb[0] !== 1'b0 || cb[0] !== 1'b0) $display("FAIL release buttons: got z=%0b c=%0b want 0 0", zb[0], cb[0]);
        else passed++;
        send_pkt(0, 48'h80FF40C020E5);
        send_pkt(0, 48'h80FF40C020E4);
        drain(0, "press sequence");
    endtask

    task automatic test_reject();
        send_pkt(1, 48'h9A3C5566A1F0);
        drain(1, "xor packet");
        send_pkt(1, 48'hFFFFFFFFFFFF);
        drain(1, "reject");
        check_held(1, "reject");
        check_status(1, "reject");
    endtask

    task automatic test_abort_timeout();
        drive(0, 8'h11, 1'b1); drive(0, 8'h22, 1'b0); drive(0, 8'h33, 1'b0);
        bump_err(0);
        send_pkt(0, 48'h7A8540C02066);
        drain(0, "abort restart");
        check_status(0, "abort restart");
        drive(0, 8'h11, 1'b1); drive(0, 8'h22, 1'b0); drive(0, 8'h33, 1'b0);
        idle(0);
        repeat (TO - 1) @(negedge clk);
        check_status(0, "before timeout");
        @(negedge clk);
        bump_err(0);
        exp_link[0] = 1'b0;
        check_status(0, "timeout");
        check_held(0, "timeout");
        drive(0, 8'h44, 1'b0);
        idle(0);
        bump_err(0);
        @(negedge clk);
        check_status(0, "idle after timeout");
        send_pkt(0, 48'h80FF40C020E4);
        drain(0, "recover");
        check_status(0, "recover");
    endtask

    task automatic test_deadzone();
        send_pkt(0, 48'h8585000000FF);
        drain(0, "dz 133");
        checks++;
        if (sx[0] !== 8'd128 || sy[0] !== 8'd128) $display("FAIL dz 133: got %0d/%0d want 128/128", sx[0], sy[0]);
        else passed++;
        send_pkt(0, 48'h8878000000FF);
        drain(0, "dz 136");
        checks++;
        if (sx[0] !== 8'd136 || sy[0] !== 8'd120) $display("FAIL dz 136: got %0d/%0d want 136/120", sx[0], sy[0]);
        else passed++;
        send_pkt(0, 48'h7B00FF0102FF);
        send_pkt(0, 48'h7F8100FF03FC);
        drain(0, "dz edges");
    endtask

    task automatic test_back_to_back();
        logic [47:0] a, b;
        a = 48'h1020304050A8;
        b = 48'hF0E0D0C0B05B;
        expect_pkt(0, a); expect_pkt(0, b);
        for (int k = 0; k < 6; k++) drive(0, a[47-8*k -: 8], k == 0);
        for (int k = 0; k < 6; k++) drive(0, b[47-8*k -: 8], k == 0);
        expect_pkt(0, a);
        for (int k = 0; k < 6; k++) drive(0, a[47-8*k -: 8], k == 0);
        drive(0, 8'h55, 1'b0);
        bump_err(0);
        idle(0);
        drain(0, "back to back");
        check_status(0, "commit-cycle byte");
    endtask

    task automatic test_random();
        logic [47:0] r;
        for (int i = 0; i < 8; i++) begin
            for (int d = 0; d < 2; d++) begin
                r = {$urandom, $urandom_range(65535, 0)};
                send_pkt(d, r[47:0]);
            end
        end
        drain(0, "random0");
        drain(1, "random1");
        check_status(1, "random1");
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 260; i++) begin
            drive(1, 8'(i), 1'b0);
            bump_err(1);
        end
        idle(1);
        @(negedge clk);
        checks++;
        if (ec[1] !== 8'd255) $display("FAIL err saturation: got %0d want 255", ec[1]);
        else passed++;
        check_status(1, "saturation");
    endtask

    task automatic test_reset_mid();
        drive(0, 8'h80, 1'b1); drive(0, 8'hFF, 1'b0); drive(0, 8'h40, 1'b0);
        idle(0);
        rst_n = 1'b0;
        #1;
        clear_models();
        check_held(0, "mid reset");
        check_status(0, "mid reset");
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 8'hC0, 1'b0); drive(0, 8'h20, 1'b0); drive(0, 8'hE4, 1'b0);
        idle(0);
        repeat (3) bump_err(0);
        drain(0, "after mid reset");
        check_status(0, "after mid reset");
        check_held(0, "after mid reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_repeat();
        test_reject();
        test_abort_timeout();
        test_deadzone();
        test_back_to_back();
        test_random();
        test_saturation();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
